// File: rtl/sp1_heap_alloc.sv
// Heap-allocation unit for the STG evaluator: hands out the current Hp as the
// base of an N-word block, then bumps Hp. If the block would cross HpLim, or
// Hp + N would wrap, the request fails and the sticky overflow flag is raised
// so that the sequencer can start GC.

// AW-bit adder that also returns the carry-out.
module sp1_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);
  assign {carry_o, sum_o} = a_i + b_i;
endmodule

// Unsigned a > b.
module sp1_comp_gt #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         gt_o
);
  assign gt_o = (a_i > b_i);
endmodule

module sp1_heap_alloc #(
  parameter int          AW       = 32,
  parameter int          NW       = 8,
  parameter logic [AW-1:0] HP_INIT  = '0,
  parameter logic [AW-1:0] LIM_INIT = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [NW-1:0] req_size,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic [AW-1:0] rsp_base,
  output logic          rsp_ovf,
  input  logic          rsp_ready,
  input  logic          hp_set,
  input  logic [AW-1:0] hp_set_val,
  input  logic          lim_set,
  input  logic [AW-1:0] lim_set_val,
  output logic [AW-1:0] hp,
  output logic [AW-1:0] hplim,
  output logic          ovf_flag,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] hp_q, hp_d;
  logic [AW-1:0] lim_q, lim_d;
  logic [NW-1:0] size_q, size_d;
  logic [AW-1:0] base_q, base_d;
  logic          rovf_q, rovf_d;
  logic          flag_q, flag_d;

  logic [AW-1:0] size_ext;
  logic [AW-1:0] end_addr;
  logic          carry;
  logic          past_lim;
  logic          ovf;

  assign size_ext = {{(AW-NW){1'b0}}, size_q};

  sp1_adder #(.W(AW)) u_add (
    .a_i     (hp_q),
    .b_i     (size_ext),
    .sum_o   (end_addr),
    .carry_o (carry)
  );

  // HpLim is exclusive, so end == HpLim still fits.
  sp1_comp_gt #(.W(AW)) u_gt (
    .a_i  (end_addr),
    .b_i  (lim_q),
    .gt_o (past_lim)
  );

  // A carry-out always fails, so Hp can never wrap around.
  assign ovf = carry | past_lim;

  // Set commands win over requests, so a request is refused while one is up.
  assign req_ready = (state_q == IDLE) & ~hp_set & ~lim_set;
  assign rsp_valid = (state_q == RESP);
  assign rsp_base  = base_q;
  assign rsp_ovf   = rovf_q;
  assign hp        = hp_q;
  assign hplim     = lim_q;
  assign ovf_flag  = flag_q;
  assign busy      = (state_q != IDLE);

  // Next-state logic for the IDLE -> CALC -> RESP handshake.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    lim_d   = lim_q;
    size_d  = size_q;
    base_d  = base_q;
    rovf_d  = rovf_q;
    flag_d  = flag_q;
    case (state_q)
      IDLE: begin
        if (hp_set) begin
          hp_d   = hp_set_val;
          flag_d = 1'b0;
        end
        if (lim_set) lim_d = lim_set_val;
        if (req_valid && req_ready) begin
          size_d  = req_size;
          state_d = CALC;
        end
      end
      CALC: begin
        base_d = hp_q;
        rovf_d = ovf;
        if (ovf) flag_d = 1'b1;
        else     hp_d   = end_addr;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight request without responding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hp_q    <= HP_INIT;
      lim_q   <= LIM_INIT;
      size_q  <= '0;
      base_q  <= '0;
      rovf_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      lim_q   <= lim_d;
      size_q  <= size_d;
      base_q  <= base_d;
      rovf_q  <= rovf_d;
      flag_q  <= flag_d;
    end
  end

endmodule
